// File: rtl/tpu_ctrl_responder.sv
// tpu_ctrl_responder
//   FPGA-side end of the HPS<->FPGA control handshake. The 32-bit control
//   word from the HPS is brought into the CLOCK domain through a 2-flop
//   synchronizer and decoded. One matrix job is launched per go handshake
//   and watched for completion or hang. A single done/status bit goes back
//   to the HPS.
//
// Ports
//   CLOCK            system clock
//   RESET_N          asynchronous active-low reset
//   control_to_FPGA  HPS control word (async): [0] clr, [1] go, [2] ack,
//                    [3] reserved, [7:4] opcode, [15:8] count,
//                    [31:16] base_addr
//   control_to_HPS   done/status back to the HPS (high in DONE and ERROR)
//   eng_start        one-cycle job launch pulse to the engine
//   eng_abort        one-cycle abort pulse when a live job is cleared
//   eng_opcode       opcode latched at launch
//   eng_count        element count latched at launch
//   eng_base_addr    base address latched at launch
//   eng_tile         job index since the last clear (wraps)
//   eng_done         engine completion pulse (only honoured in RUN)
//   err              sticky timeout flag, cleared only by clr
module tpu_ctrl_responder #(
  parameter int TILE_W         = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [31:0]       control_to_FPGA,
  output logic              control_to_HPS,
  output logic              eng_start,
  output logic              eng_abort,
  output logic [3:0]        eng_opcode,
  output logic [7:0]        eng_count,
  output logic [15:0]       eng_base_addr,
  output logic [TILE_W-1:0] eng_tile,
  input  logic              eng_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_ACK_LOW,
    S_ERROR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [31:0]      ctl_meta;
  logic [31:0]      ctl_sync;
  logic [TO_W-1:0]  to_cnt;
  logic             abort_q;

  logic             clr_s;
  logic             go_s;
  logic             ack_s;
  logic             unused_reserved;

  assign clr_s           = ctl_sync[0];
  assign go_s            = ctl_sync[1];
  assign ack_s           = ctl_sync[2];
  assign unused_reserved = ctl_sync[3];

  // Whole word is synchronized; the HPS keeps [31:4] stable while go is
  // high, so no per-field skew handling is needed.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctl_meta <= '0;
      ctl_sync <= '0;
    end else begin
      ctl_meta <= control_to_FPGA;
      ctl_sync <= ctl_meta;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr_s) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (go_s) next_state = S_LAUNCH;
        S_LAUNCH:  next_state = S_RUN;
        // Completion is checked before expiry so a coincident done wins.
        S_RUN: begin
          if (eng_done)              next_state = S_DONE;
          else if (to_cnt == TO_LAST) next_state = S_ERROR;
        end
        S_DONE:    if (ack_s) next_state = S_ACK_LOW;
        S_ACK_LOW: begin
          if (!ack_s) next_state = go_s ? S_LAUNCH : S_IDLE;
        end
        S_ERROR:   next_state = S_ERROR;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // Job fields, tile index, timeout counter and the abort pulse.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      eng_opcode    <= '0;
      eng_count     <= '0;
      eng_base_addr <= '0;
      eng_tile      <= '0;
      to_cnt        <= '0;
      abort_q       <= 1'b0;
    end else begin
      abort_q <= clr_s && ((state == S_LAUNCH) || (state == S_RUN));

      // next_state can only be LAUNCH when clr_s is low.
      if (next_state == S_LAUNCH) begin
        eng_opcode    <= ctl_sync[7:4];
        eng_count     <= ctl_sync[15:8];
        eng_base_addr <= ctl_sync[31:16];
      end

      if (clr_s)
        eng_tile <= '0;
      else if ((state == S_DONE) && ack_s)
        eng_tile <= eng_tile + 1'b1;

      if (state == S_LAUNCH)
        to_cnt <= '0;
      else if ((state == S_RUN) && !eng_done && (to_cnt != TO_LAST))
        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    eng_start      = (state == S_LAUNCH) && !clr_s;
    eng_abort      = abort_q;
    control_to_HPS = (state == S_DONE) || (state == S_ERROR);
    err            = (state == S_ERROR);
  end

endmodule

// File: tb/tb_tpu_ctrl_responder.sv
// Directed bench for tpu_ctrl_responder (TILE_W=2, TIMEOUT_CYCLES=16).
// Inputs change on the falling edge; outputs are sampled on the next
// falling edge, half a cycle after the rising edge that consumed them.
module tb_tpu_ctrl_responder;

  localparam int TILE_W  = 2;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  localparam logic [31:0] W_GO  = 32'h080040A2;
  localparam logic [31:0] W_ACK = 32'h080040A6;

  logic              CLOCK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [31:0]       control_to_FPGA = '0;
  logic              control_to_HPS;
  logic              eng_start;
  logic              eng_abort;
  logic [3:0]        eng_opcode;
  logic [7:0]        eng_count;
  logic [15:0]       eng_base_addr;
  logic [TILE_W-1:0] eng_tile;
  logic              eng_done = 1'b0;
  logic              err;

  int tests = 0;
  int fails = 0;

  tpu_ctrl_responder #(
    .TILE_W(TILE_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W(TO_W)
  ) dut (
    .CLOCK(CLOCK),
    .RESET_N(RESET_N),
    .control_to_FPGA(control_to_FPGA),
    .control_to_HPS(control_to_HPS),
    .eng_start(eng_start),
    .eng_abort(eng_abort),
    .eng_opcode(eng_opcode),
    .eng_count(eng_count),
    .eng_base_addr(eng_base_addr),
    .eng_tile(eng_tile),
    .eng_done(eng_done),
    .err(err)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] ctl;
    logic        done;
    int unsigned reps;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] c, input logic d,
                              input int unsigned r, input logic hps,
                              input logic st, input logic [3:0] op,
                              input logic [7:0] cn, input logic [15:0] ba,
                              input logic [1:0] tl, input logic e);
    vec_t v;
    v.ctl  = c;
    v.done = d;
    v.reps = r;
    v.exp  = {hps, st, 1'b0, op, cn, ba, tl, e};
    return v;
  endfunction

  function automatic logic [33:0] outs();
    return {control_to_HPS, eng_start, eng_abort, eng_opcode, eng_count,
            eng_base_addr, eng_tile, err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Advance until eng_start is seen (at most budget cycles).
  task automatic wait_start(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (eng_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  int exp_tiles[5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;

    // Table: single job then ack and back-to-back job.
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 1, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 0, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 8, 0, 0, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b1, 1, 1, 0, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 3, 1, 0, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_ACK, 1'b0, 1, 1, 0, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 1, 0, 4'hA, 8'h40, 16'h0800, 2'd0, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 0, 4'hA, 8'h40, 16'h0800, 2'd1, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 1, 4'hA, 8'h40, 16'h0800, 2'd1, 0));
    vecs.push_back(mk(W_GO,  1'b0, 1, 0, 0, 4'hA, 8'h40, 16'h0800, 2'd1, 0));
    vecs.push_back(mk(W_GO,  1'b0, 4, 0, 0, 4'hA, 8'h40, 16'h0800, 2'd1, 0));
    vecs.push_back(mk(W_GO,  1'b1, 1, 1, 0, 4'hA, 8'h40, 16'h0800, 2'd1, 0));
    vecs.push_back(mk(W_GO,  1'b0, 2, 1, 0, 4'hA, 8'h40, 16'h0800, 2'd1, 0));

    // Reset, async reset mid-RUN, then clr+go together.
    cyc(2);
    chk("reset_outs", 64'(outs()), 64'd0);
    RESET_N = 1'b1;
    cyc(2);
    control_to_FPGA = 32'h123456F2;
    wait_start("pre_reset_start", 8);
    cyc(3);
    chk("pre_reset_fields", 64'({eng_opcode, eng_count, eng_base_addr}),
        64'({4'hF, 8'h56, 16'h1234}));
    #2 RESET_N = 1'b0;
    #1 chk("async_reset_outs", 64'(outs()), 64'd0);
    control_to_FPGA = 32'h00000003;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (eng_start) n++;
    end
    chk("no_start_under_clr", 64'(n), 64'd0);
    chk("clr_outs", 64'(outs()), 64'd0);
    control_to_FPGA = '0;
    cyc(4);

    foreach (vecs[i]) begin
      for (int unsigned r = 0; r < vecs[i].reps; r++) begin
        control_to_FPGA = vecs[i].ctl;
        eng_done        = vecs[i].done;
        cyc(1);
        chk($sformatf("vec%0d_rep%0d", i, r), 64'(outs()), 64'(vecs[i].exp));
      end
    end
    eng_done = 1'b0;

    // Ack the second job, let the third launch, clear it during RUN.
    control_to_FPGA = W_ACK;
    cyc(1);
    control_to_FPGA = W_GO;
    wait_start("third_start", 10);
    chk("third_tile", 64'(eng_tile), 64'd2);
    cyc(3);
    control_to_FPGA = 32'h00000001;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (eng_abort) n++;
    end
    chk("abort_once", 64'(n), 64'd1);
    chk("abort_tile_cleared", 64'(eng_tile), 64'd0);
    chk("abort_status", 64'({control_to_HPS, err, eng_start}), 64'd0);
    control_to_FPGA = '0;
    cyc(4);

    // eng_done in IDLE is ignored.
    eng_done = 1'b1;
    cyc(1);
    eng_done = 1'b0;
    chk("idle_done_ignored_a", 64'({control_to_HPS, eng_start, err}), 64'd0);
    cyc(3);
    chk("idle_done_ignored_b", 64'({control_to_HPS, eng_start, err}), 64'd0);

    // eng_done on the timeout cycle: DONE wins.
    control_to_FPGA = 32'h00000012;
    wait_start("coincide_start", 8);
    cyc(16);
    chk("coincide_pre", 64'({control_to_HPS, err}), 64'd0);
    eng_done = 1'b1;
    cyc(1);
    eng_done = 1'b0;
    chk("coincide_done_wins", 64'({control_to_HPS, err}), 64'b10);
    cyc(2);
    chk("coincide_err_stays_0", 64'({control_to_HPS, err}), 64'b10);
    control_to_FPGA = 32'h00000001;
    cyc(4);
    control_to_FPGA = '0;
    cyc(4);
    chk("coincide_cleared", 64'(control_to_HPS), 64'd0);

    // Timeout: 16 RUN cycles then ERROR; ack ignored; clr recovers.
    control_to_FPGA = 32'h00000002;
    wait_start("timeout_start", 8);
    cyc(16);
    chk("timeout_not_yet", 64'({control_to_HPS, err}), 64'd0);
    cyc(1);
    chk("timeout_err", 64'({control_to_HPS, err}), 64'b11);
    control_to_FPGA = 32'h00000006;
    cyc(6);
    chk("timeout_ack_ignored", 64'({control_to_HPS, err}), 64'b11);
    control_to_FPGA = 32'h00000001;
    cyc(3);
    chk("timeout_clr", 64'({control_to_HPS, err, eng_tile}), 64'd0);
    control_to_FPGA = '0;
    cyc(4);

    // Tile wrap under continuous go.
    control_to_FPGA = 32'h00000002;
    for (int j = 0; j < 5; j++) begin
      wait_start($sformatf("wrap_start%0d", j), 12);
      chk($sformatf("wrap_tile%0d", j), 64'(eng_tile), 64'(exp_tiles[j]));
      cyc(1);
      eng_done = 1'b1;
      cyc(1);
      eng_done = 1'b0;
      chk($sformatf("wrap_done%0d", j), 64'(control_to_HPS), 64'd1);
      control_to_FPGA = 32'h00000006;
      cyc(1);
      control_to_FPGA = 32'h00000002;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
